// File: rtl/display_saver_ctrl.sv
// display_saver_ctrl
//   Drives the stopwatch 7-segment display. In SHOW mode the BCD digits are
//   time-multiplexed onto one shared segment bus. After an idle timeout the
//   controller enters SAVER mode, where one segment (a..g) is lit at a time
//   and the lit segment walks across the digits.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   activity      button press / stopwatch running; any 1 resets the idle timer
//   digit_bcd     4 bits per digit, digit 0 (rightmost) in [3:0]
//   seg_n         segments {g,f,e,d,c,b,a}, active low, registered
//   an_n          digit enables, active low, registered
//   saver_active  1 while in SAVER, registered
//   seg_idx       current saver segment index 0..6 (0=a), registered
//
// Build option
//   SEG_LEADING_ZERO_BLANK_EN : blank leading zero digits in SHOW mode
//   (digit 0 is never blanked). SAVER mode is unaffected.
//
// state | meaning
// ------+---------------------------------------------------------
// SHOW  | multiplex BCD digits, count idle cycles toward timeout
// SAVER | single-segment animation, any activity returns to SHOW

module display_saver_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int STEP_DIV     = 5000000,
  parameter int IDLE_TIMEOUT = 500000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    activity,
  input  logic [4*NUM_DIGITS-1:0] digit_bcd,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    saver_active,
  output logic [2:0]              seg_idx
);

  localparam int POS_W  = $clog2(NUM_DIGITS);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int STEP_W = $clog2(STEP_DIV);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0] SCAN_TERM = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_TERM = STEP_W'(STEP_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_TERM = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_SAVER = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    scan_pos_q, scan_pos_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [2:0]          cur_seg_q, cur_seg_d;
  logic [POS_W-1:0]    saver_pos_q, saver_pos_d;

  logic [6:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  saver_active_q, saver_active_d;
  logic [2:0]            seg_idx_q, seg_idx_d;

  logic [3:0]            cur_digit;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic                  blank;
`endif

  function automatic logic [6:0] bcd_to_seg_n(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // non-BCD code: dash
    endcase
    return s;
  endfunction

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    scan_pos_d  = scan_pos_q;
    scan_cnt_d  = scan_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    step_cnt_d  = step_cnt_q;
    cur_seg_d   = cur_seg_q;
    saver_pos_d = saver_pos_q;

    case (state_q)
      ST_SHOW: begin
        if (scan_cnt_q == SCAN_TERM) begin
          scan_cnt_d = '0;
          scan_pos_d = (scan_pos_q == POS_LAST) ? '0 : scan_pos_q + POS_W'(1);
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end

        // Activity wins over a timeout that lands in the same cycle.
        if (activity) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_TERM) begin
          state_d     = ST_SAVER;
          idle_cnt_d  = '0;
          step_cnt_d  = '0;
          cur_seg_d   = '0;
          saver_pos_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end

      ST_SAVER: begin
        idle_cnt_d = '0;
        if (activity) begin
          // cur_seg is deliberately kept so the animation index stays visible.
          state_d    = ST_SHOW;
          scan_cnt_d = '0;
          scan_pos_d = '0;
        end else if (step_cnt_q == STEP_TERM) begin
          step_cnt_d = '0;
          if (cur_seg_q == 3'd6) begin
            cur_seg_d   = '0;
            saver_pos_d = (saver_pos_q == POS_LAST) ? '0 : saver_pos_q + POS_W'(1);
          end else begin
            cur_seg_d = cur_seg_q + 3'd1;
          end
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end

      default: state_d = ST_SHOW;
    endcase
  end

  // Output logic, registered below for glitch-free pins
  always_comb begin
    seg_n_d        = 7'h7F;
    an_n_d         = '1;
    saver_active_d = (state_q == ST_SAVER);
    seg_idx_d      = cur_seg_q;
    cur_digit      = 4'd0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank          = 1'b0;
`endif

    if (state_q == ST_SAVER) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (POS_W'(i) == saver_pos_q) an_n_d[i] = 1'b0;
      end
      for (int i = 0; i < 7; i++) begin
        if (3'(i) == cur_seg_q) seg_n_d[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (POS_W'(i) == scan_pos_q) begin
          an_n_d[i] = 1'b0;
          cur_digit = digit_bcd[i*4 +: 4];
        end
      end
      seg_n_d = bcd_to_seg_n(cur_digit);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      // Blank when this digit and every higher digit are zero; digit 0 always shows.
      blank = (scan_pos_q != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((POS_W'(i) >= scan_pos_q) && (digit_bcd[i*4 +: 4] != 4'd0)) blank = 1'b0;
      end
      if (blank) seg_n_d = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_SHOW;
      scan_pos_q     <= '0;
      scan_cnt_q     <= '0;
      idle_cnt_q     <= '0;
      step_cnt_q     <= '0;
      cur_seg_q      <= '0;
      saver_pos_q    <= '0;
      seg_n_q        <= 7'h7F;
      an_n_q         <= '1;
      saver_active_q <= 1'b0;
      seg_idx_q      <= '0;
    end else begin
      state_q        <= state_d;
      scan_pos_q     <= scan_pos_d;
      scan_cnt_q     <= scan_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      step_cnt_q     <= step_cnt_d;
      cur_seg_q      <= cur_seg_d;
      saver_pos_q    <= saver_pos_d;
      seg_n_q        <= seg_n_d;
      an_n_q         <= an_n_d;
      saver_active_q <= saver_active_d;
      seg_idx_q      <= seg_idx_d;
    end
  end

  assign seg_n        = seg_n_q;
  assign an_n         = an_n_q;
  assign saver_active = saver_active_q;
  assign seg_idx      = seg_idx_q;

endmodule

// File: tb/tb_display_saver_ctrl.sv
// Testbench for display_saver_ctrl with NUM_DIGITS=4, SCAN_DIV=4, STEP_DIV=3,
// IDLE_TIMEOUT=20. Expected outputs are pushed to a queue as each step's
// stimulus is applied and popped once the clock has advanced to the point
// where the DUT must present them.

module tb_display_saver_ctrl;

  localparam int NUM_DIGITS   = 4;
  localparam int SCAN_DIV     = 4;
  localparam int STEP_DIV     = 3;
  localparam int IDLE_TIMEOUT = 20;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    activity;
  logic [4*NUM_DIGITS-1:0] digit_bcd;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    saver_active;
  logic [2:0]              seg_idx;

  display_saver_ctrl #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .STEP_DIV    (STEP_DIV),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .activity    (activity),
    .digit_bcd   (digit_bcd),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .saver_active(saver_active),
    .seg_idx     (seg_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [6:0] seg;
    logic [3:0] an;
    logic       act;
    logic [2:0] idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic push_exp(input string tag, input logic [6:0] seg, input logic [3:0] an,
                          input logic act, input logic [2:0] idx);
    exp_t e;
    e.tag = tag;
    e.seg = seg;
    e.an  = an;
    e.act = act;
    e.idx = idx;
    sb_q.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    n_total++;
    assert (sb_q.size() != 0) n_pass++;
    else $error("FAIL scoreboard_empty got size 0 expected nonzero");
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_total++;
      assert (seg_n === e.seg) n_pass++;
      else $error("FAIL %s seg_n got %h expected %h", e.tag, seg_n, e.seg);
      n_total++;
      assert (an_n === e.an) n_pass++;
      else $error("FAIL %s an_n got %h expected %h", e.tag, an_n, e.an);
      n_total++;
      assert (saver_active === e.act) n_pass++;
      else $error("FAIL %s saver_active got %b expected %b", e.tag, saver_active, e.act);
      n_total++;
      assert (seg_idx === e.idx) n_pass++;
      else $error("FAIL %s seg_idx got %0d expected %0d", e.tag, seg_idx, e.idx);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect the given outputs n clock cycles from now (sampled at falling edge).
  task automatic step(input int n, input string tag, input logic [6:0] seg,
                      input logic [3:0] an, input logic act, input logic [2:0] idx);
    push_exp(tag, seg, an, act, idx);
    tick(n);
    check_front();
  endtask

  initial begin
    reset_n   = 1'b0;
    activity  = 1'b1;
    digit_bcd = 16'h1234;
    tick(1);
    push_exp("reset_init", 7'h7F, 4'hF, 1'b0, 3'd0);
    check_front();

    // Scan with activity held: 4 clk per digit, digit 0 first.
    reset_n = 1'b1;
    step(1,  "scan_d0",       7'h19, 4'hE, 1'b0, 3'd0);
    step(3,  "scan_d0_hold",  7'h19, 4'hE, 1'b0, 3'd0);
    step(1,  "scan_d1",       7'h30, 4'hD, 1'b0, 3'd0);
    step(4,  "scan_d2",       7'h24, 4'hB, 1'b0, 3'd0);
    step(4,  "scan_d3",       7'h79, 4'h7, 1'b0, 3'd0);
    step(4,  "scan_wrap",     7'h19, 4'hE, 1'b0, 3'd0);

    // Idle timeout: 20 quiet cycles, saver visible on the 21st.
    activity = 1'b0;
    step(20, "pre_timeout",   7'h30, 4'hD, 1'b0, 3'd0);
    step(1,  "saver_entry",   7'h7E, 4'hE, 1'b1, 3'd0);
    step(2,  "step0_hold",    7'h7E, 4'hE, 1'b1, 3'd0);
    step(1,  "step1",         7'h7D, 4'hE, 1'b1, 3'd1);
    step(3,  "step2",         7'h7B, 4'hE, 1'b1, 3'd2);
    step(12, "step6",         7'h3F, 4'hE, 1'b1, 3'd6);
    step(3,  "saver_pos1",    7'h7E, 4'hD, 1'b1, 3'd0);
    step(3,  "pos1_step1",    7'h7D, 4'hD, 1'b1, 3'd1);

    // One-cycle activity pulse exits SAVER; seg_idx keeps its value.
    activity = 1'b1;
    step(1,  "exit_pending",  7'h7D, 4'hD, 1'b1, 3'd1);
    activity = 1'b0;
    step(1,  "exit_show",     7'h19, 4'hE, 1'b0, 3'd1);
    step(3,  "exit_d0_hold",  7'h19, 4'hE, 1'b0, 3'd1);
    step(1,  "exit_d1",       7'h30, 4'hD, 1'b0, 3'd1);

    // Activity lands exactly on the last idle cycle: stay SHOW, restart 20.
    tick(14);
    activity = 1'b1;
    step(1,  "race_hit",      7'h19, 4'hE, 1'b0, 3'd1);
    activity = 1'b0;
    step(1,  "race_show",     7'h30, 4'hD, 1'b0, 3'd1);
    step(19, "race_pre_to",   7'h30, 4'hD, 1'b0, 3'd1);
    step(1,  "race_saver",    7'h7E, 4'hE, 1'b1, 3'd0);
    step(6,  "saver_idx2",    7'h7B, 4'hE, 1'b1, 3'd2);

    // Reset mid-animation takes effect without a clock edge.
    reset_n = 1'b0;
    push_exp("reset_mid", 7'h7F, 4'hF, 1'b0, 3'd0);
    #1;
    check_front();
    digit_bcd = 16'h0070;
    activity  = 1'b1;
    tick(1);
    push_exp("reset_held", 7'h7F, 4'hF, 1'b0, 3'd0);
    check_front();

    // Leading zeros, live digit sampling and the non-BCD dash.
    reset_n = 1'b1;
    step(1,  "lz_d0",         7'h40, 4'hE, 1'b0, 3'd0);
    digit_bcd = 16'h007A;
    step(1,  "dash",          7'h3F, 4'hE, 1'b0, 3'd0);
    digit_bcd = 16'h0070;
    step(1,  "lz_d0_back",    7'h40, 4'hE, 1'b0, 3'd0);
    step(2,  "lz_d1",         7'h78, 4'hD, 1'b0, 3'd0);
    step(4,  "lz_d2",         LZ_SEG, 4'hB, 1'b0, 3'd0);
    step(4,  "lz_d3",         LZ_SEG, 4'h7, 1'b0, 3'd0);
    step(4,  "lz_wrap",       7'h40, 4'hE, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
